commit_cmp: RTL and testbench
=============================

Name: commit_cmp

Overview:
- Lockstep retire-stream comparator between the DUT core and the reference core in the simulation hierarchy.
- Each side pushes retired-instruction records into its own FIFO. Heads are popped in pairs and compared field by field.
- First divergence, a stalled side, or an end-of-test drain is reported through registered status outputs.
- Generalises the single-reference harness with buffering, backpressure, timeout detection and pass/fail sequencing.

Parameters:
- XLEN, 32, data/PC width (from defines).
- FIFO_DEPTH, 8, entries per side FIFO; power of two, at least 2.
- TIMEOUT_CYC, 1024, cycles one side may hold entries while the other is empty before failing.
- CNT_W, 32, width of the match counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; IDLE->RUN.
- halt  in  1  end-of-test request; RUN->DRAIN.
- dut_valid  in  1  DUT retire record valid.
- dut_ready  out  1  DUT record accepted when valid&&ready.
- dut_pc  in  XLEN  retired PC.
- dut_instr  in  32  retired instruction.
- dut_rd_we  in  1  register write.
- dut_rd_addr  in  5  destination register.
- dut_rd_data  in  XLEN  write data.
- ref_valid, ref_ready, ref_pc, ref_instr, ref_rd_we, ref_rd_addr, ref_rd_data  same as dut_*, for the reference side.
- state_o  out  3  cmp_state_t.
- err_code  out  2  0 none, 1 mismatch, 2 timeout.
- fail_pc  out  XLEN  DUT head PC at failure.
- match_cnt  out  CNT_W  compared-equal pairs.
- pass  out  1  sticky drain success.
- fail  out  1  sticky failure.
- mm_dut_rec  out  record width  failing DUT record (optional feature).
- mm_ref_rec  out  record width  failing reference record (optional feature).

Behaviour:
- Reset, synchronous and active-high:
  - state IDLE, FIFOs empty.
  - match_cnt, timeout counter, err_code, fail_pc, pass, fail all 0.
  - ready outputs 0.
  - Asserting rst mid-test discards all buffered records.
- Readiness: x_ready = !x_full while in RUN or DRAIN; 0 in IDLE, PASS and FAIL.
  - A push is never accepted at full, even if a pop occurs in the same cycle.
- States:
  - IDLE -> RUN on start.
  - RUN -> DRAIN on halt.
  - RUN or DRAIN -> FAIL on mismatch or timeout.
  - DRAIN -> PASS when both FIFOs are empty at a clock edge.
  - PASS and FAIL are terminal until rst.
  - start is ignored outside IDLE. halt is ignored outside RUN.
- Compare: at any edge in RUN or DRAIN with both FIFOs non-empty, pop both heads.
  - Equal when pc, instr and rd_we all match.
  - Additionally, when rd_we=1 and rd_addr!=0, rd_addr and rd_data must match.
  - rd fields are ignored when rd_we=0 or rd_addr=0.
  - Equal: match_cnt increments, saturating at all-ones.
  - Not equal: at the same edge, state FAIL, err_code=1, fail=1, fail_pc=DUT head PC.
  - Latency: the result is visible the cycle after the pop edge. At most one pair is compared per cycle.
- Timeout: counter increments each RUN/DRAIN cycle in which exactly one FIFO is non-empty; otherwise it clears.
  - On the edge where the counter reaches TIMEOUT_CYC-1 and increments: FAIL, err_code=2, fail_pc = non-empty side's head PC.
- Simultaneous events:
  - Mismatch and timeout on the same edge: mismatch wins.
  - halt and mismatch on the same edge: FAIL.
  - Push and pop on the same FIFO in the same cycle: occupancy unchanged.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits, using the wrap bit for full/empty.

Optional Feature:
- Macro: COMMIT_CMP_LOG_EN.
- Defined: on the failing edge, mm_dut_rec and mm_ref_rec capture the two head records (for timeout, the empty side captures 0). Values hold until rst.
- Undefined: both ports are tied to 0 and no capture registers exist.

Decomposition:
- Package cmp_defines holds:
  - commit_rec_t (packed struct: pc, instr, rd_we, rd_addr, rd_data);
  - cmp_state_t enum (IDLE, RUN, DRAIN, PASS, FAIL);
  - err code localparams ERR_NONE, ERR_MISMATCH, ERR_TIMEOUT.
  XLEN comes from defines.
- Sub-module commit_fifo: parametrised synchronous FIFO of commit_rec_t, instantiated once per side.

Test Plan:
- Lockstep match: start, push 20 identical records (pc 0x0,0x4,...) on both sides in the same cycles, then halt -> match_cnt=20, state PASS, pass=1, err_code=0.
- Skewed arrival: reference side lags DUT by 5 cycles over 8 records, FIFO_DEPTH=8 -> DUT never backpressured, all 8 match, no timeout.
- Data mismatch: 4th pair has rd_we=1, rd_addr=5, DUT rd_data 0x11 vs reference 0x12 at pc 0xC -> FAIL, err_code=1, fail_pc=0xC, match_cnt=3; with COMMIT_CMP_LOG_EN, both records captured.
- x0 masking: pair with rd_addr=0 and differing rd_data -> counted as a match.
- Timeout: TIMEOUT_CYC=16, push one DUT record and no reference record -> FAIL 16 cycles later, err_code=2, fail_pc = that DUT record's PC.
- Backpressure and reset: fill DUT FIFO to 8 with the reference idle -> dut_ready=0; assert rst for one cycle -> state IDLE, FIFOs empty, match_cnt=0.

Source files
------------

// File: rtl/cmp_defines.sv
// Shared types for the lockstep retire-stream comparator.
// Record layout, FSM states, error codes and the record-compare rule.
package cmp_defines;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            rd_we;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
  } commit_rec_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    PASS  = 3'd3,
    FAIL  = 3'd4
  } cmp_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  // rd fields only matter for a real register write (not x0)
  function automatic logic rec_eq(commit_rec_t a, commit_rec_t b);
    logic eq;
    eq = (a.pc == b.pc) && (a.instr == b.instr) &&
         (a.rd_we == b.rd_we);
    if (a.rd_we && (a.rd_addr != 5'd0))
      eq = eq && (a.rd_addr == b.rd_addr) &&
           (a.rd_data == b.rd_data);
    return eq;
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO of retire records, one per compared core.
// Pointers carry an extra wrap bit to tell full from empty.
module commit_fifo
  import cmp_defines::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  commit_rec_t din,
  input  logic        pop,
  output commit_rec_t dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  commit_rec_t     mem [DEPTH];
  logic [AW:0]     wp;
  logic [AW:0]     rp;
  logic            do_push;
  logic            do_pop;

  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign empty   = (wp == rp);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp[AW-1:0]];

  // pointer update; reset discards all buffered records
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  // storage write, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/commit_cmp.sv
// Lockstep comparator of DUT and reference retire streams.
// Optional failing-record capture: define COMMIT_CMP_LOG_EN.
module commit_cmp
  import cmp_defines::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic             dut_valid,
  output logic             dut_ready,
  input  logic [XLEN-1:0]  dut_pc,
  input  logic [31:0]      dut_instr,
  input  logic             dut_rd_we,
  input  logic [4:0]       dut_rd_addr,
  input  logic [XLEN-1:0]  dut_rd_data,
  input  logic             ref_valid,
  output logic             ref_ready,
  input  logic [XLEN-1:0]  ref_pc,
  input  logic [31:0]      ref_instr,
  input  logic             ref_rd_we,
  input  logic [4:0]       ref_rd_addr,
  input  logic [XLEN-1:0]  ref_rd_data,
  output logic [2:0]       state_o,
  output logic [1:0]       err_code,
  output logic [XLEN-1:0]  fail_pc,
  output logic [CNT_W-1:0] match_cnt,
  output logic             pass,
  output logic             fail,
  output commit_rec_t      mm_dut_rec,
  output commit_rec_t      mm_ref_rec
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);

  cmp_state_t  st;
  logic [TW-1:0] tcnt;
  commit_rec_t d_in, r_in, d_head, r_head;
  logic d_full, d_empty, r_full, r_empty;
  logic act, both, one, eq, mism, tmo;

  assign d_in = '{pc: dut_pc, instr: dut_instr,
                  rd_we: dut_rd_we, rd_addr: dut_rd_addr,
                  rd_data: dut_rd_data};
  assign r_in = '{pc: ref_pc, instr: ref_instr,
                  rd_we: ref_rd_we, rd_addr: ref_rd_addr,
                  rd_data: ref_rd_data};

  assign act       = (st == RUN) || (st == DRAIN);
  assign dut_ready = act && !d_full;
  assign ref_ready = act && !r_full;
  assign both      = act && !d_empty && !r_empty;
  assign one       = act && (d_empty != r_empty);
  assign eq        = rec_eq(d_head, r_head);
  assign mism      = both && !eq;
  assign tmo       = one && (tcnt == TLIM);
  assign state_o   = st;

  commit_fifo #(.DEPTH(FIFO_DEPTH)) u_dut_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dut_valid && dut_ready),
    .din   (d_in),
    .pop   (both),
    .dout  (d_head),
    .full  (d_full),
    .empty (d_empty)
  );

  commit_fifo #(.DEPTH(FIFO_DEPTH)) u_ref_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ref_valid && ref_ready),
    .din   (r_in),
    .pop   (both),
    .dout  (r_head),
    .full  (r_full),
    .empty (r_empty)
  );

  // sequencing FSM with registered status; mismatch beats timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      err_code <= ERR_NONE;
      fail_pc  <= '0;
      pass     <= 1'b0;
      fail     <= 1'b0;
    end else if (mism) begin
      st       <= FAIL;
      err_code <= ERR_MISMATCH;
      fail_pc  <= d_head.pc;
      fail     <= 1'b1;
    end else if (tmo) begin
      st       <= FAIL;
      err_code <= ERR_TIMEOUT;
      fail_pc  <= d_empty ? r_head.pc : d_head.pc;
      fail     <= 1'b1;
    end else begin
      unique case (st)
        IDLE:    if (start) st <= RUN;
        RUN:     if (halt) st <= DRAIN;
        DRAIN: begin
          if (d_empty && r_empty) begin
            st   <= PASS;
            pass <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // saturating count of equal pairs
  always_ff @(posedge clk) begin
    if (rst)
      match_cnt <= '0;
    else if (both && eq && !(&match_cnt))
      match_cnt <= match_cnt + 1'b1;
  end

  // cycles spent with exactly one side holding records
  always_ff @(posedge clk) begin
    if (rst)     tcnt <= '0;
    else if (one) tcnt <= tcnt + 1'b1;
    else          tcnt <= '0;
  end

`ifdef COMMIT_CMP_LOG_EN
  commit_rec_t mm_d_q, mm_r_q;

  // snapshot both heads on the failing edge
  always_ff @(posedge clk) begin
    if (rst) begin
      mm_d_q <= '0;
      mm_r_q <= '0;
    end else if (mism) begin
      mm_d_q <= d_head;
      mm_r_q <= r_head;
    end else if (tmo) begin
      mm_d_q <= d_empty ? '0 : d_head;
      mm_r_q <= r_empty ? '0 : r_head;
    end
  end

  assign mm_dut_rec = mm_d_q;
  assign mm_ref_rec = mm_r_q;
`else
  assign mm_dut_rec = '0;
  assign mm_ref_rec = '0;
`endif

endmodule

// File: tb/tb_commit_cmp.sv
// Bench for commit_cmp: queue-based reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_commit_cmp;
  import cmp_defines::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst, start, halt;
  logic dut_valid, ref_valid, dut_ready, ref_ready;
  logic [31:0] dut_pc, dut_instr, dut_rd_data;
  logic [31:0] ref_pc, ref_instr, ref_rd_data;
  logic dut_rd_we, ref_rd_we;
  logic [4:0] dut_rd_addr, ref_rd_addr;
  logic [2:0] state_o;
  logic [1:0] err_code;
  logic [31:0] fail_pc, match_cnt;
  logic pass, fail;
  commit_rec_t mm_dut_rec, mm_ref_rec;

  always #5 clk = ~clk;

  commit_cmp #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .dut_valid(dut_valid), .dut_ready(dut_ready),
    .dut_pc(dut_pc), .dut_instr(dut_instr),
    .dut_rd_we(dut_rd_we), .dut_rd_addr(dut_rd_addr),
    .dut_rd_data(dut_rd_data),
    .ref_valid(ref_valid), .ref_ready(ref_ready),
    .ref_pc(ref_pc), .ref_instr(ref_instr),
    .ref_rd_we(ref_rd_we), .ref_rd_addr(ref_rd_addr),
    .ref_rd_data(ref_rd_data),
    .state_o(state_o), .err_code(err_code), .fail_pc(fail_pc),
    .match_cnt(match_cnt), .pass(pass), .fail(fail),
    .mm_dut_rec(mm_dut_rec), .mm_ref_rec(mm_ref_rec)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic commit_rec_t mk(logic [31:0] pc, logic we,
                                     logic [4:0] a, logic [31:0] d);
    commit_rec_t r;
    r.pc      = pc;
    r.instr   = 32'h0010_0093 + pc;
    r.rd_we   = we;
    r.rd_addr = a;
    r.rd_data = d;
    return r;
  endfunction

  task automatic set_d(commit_rec_t r);
    dut_pc = r.pc; dut_instr = r.instr; dut_rd_we = r.rd_we;
    dut_rd_addr = r.rd_addr; dut_rd_data = r.rd_data;
  endtask

  task automatic set_r(commit_rec_t r);
    ref_pc = r.pc; ref_instr = r.instr; ref_rd_we = r.rd_we;
    ref_rd_addr = r.rd_addr; ref_rd_data = r.rd_data;
  endtask

  // ---------------- reference model ----------------
  commit_rec_t dq[$];
  commit_rec_t rq[$];
  cmp_state_t  m_st = IDLE;
  logic [31:0] m_cnt = '0;
  logic [1:0]  m_err = '0;
  logic [31:0] m_fpc = '0;
  bit m_pass = 0, m_fail = 0, chk_en = 0;
  int m_to = 0;
  commit_rec_t m_mmd = '0, m_mmr = '0;

  function automatic bit spec_eq(commit_rec_t d, commit_rec_t r);
    if (d.pc != r.pc || d.instr != r.instr || d.rd_we != r.rd_we)
      return 0;
    if (d.rd_we && d.rd_addr != 5'd0)
      return (d.rd_addr == r.rd_addr) && (d.rd_data == r.rd_data);
    return 1;
  endfunction

  always @(posedge clk) begin : model
    bit act, dpush, rpush, dn, rn, bad;
    commit_rec_t hd, hr, ind, inr;
    ind = '{pc: dut_pc, instr: dut_instr, rd_we: dut_rd_we,
            rd_addr: dut_rd_addr, rd_data: dut_rd_data};
    inr = '{pc: ref_pc, instr: ref_instr, rd_we: ref_rd_we,
            rd_addr: ref_rd_addr, rd_data: ref_rd_data};
    if (rst) begin
      dq.delete(); rq.delete();
      m_st <= IDLE; m_cnt <= '0; m_err <= '0; m_fpc <= '0;
      m_pass <= 0; m_fail <= 0; m_to <= 0;
      m_mmd <= '0; m_mmr <= '0;
      chk_en <= 1;
    end else begin
      act   = (m_st == RUN) || (m_st == DRAIN);
      dpush = act && dut_valid && (dq.size() < DEPTH);
      rpush = act && ref_valid && (rq.size() < DEPTH);
      dn    = dq.size() > 0;
      rn    = rq.size() > 0;
      bad   = 0;
      if (act && dn && rn) begin
        hd = dq.pop_front();
        hr = rq.pop_front();
        m_to <= 0;
        if (spec_eq(hd, hr)) begin
          if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 1;
        end else begin
          bad = 1;
          m_st <= FAIL; m_err <= 2'd1; m_fpc <= hd.pc; m_fail <= 1;
`ifdef COMMIT_CMP_LOG_EN
          m_mmd <= hd; m_mmr <= hr;
`endif
        end
      end else if (act && (dn != rn)) begin
        if (m_to == TMO - 1) begin
          bad = 1;
          m_st <= FAIL; m_err <= 2'd2; m_fail <= 1;
          m_fpc <= dn ? dq[0].pc : rq[0].pc;
`ifdef COMMIT_CMP_LOG_EN
          m_mmd <= dn ? dq[0] : '0;
          m_mmr <= rn ? rq[0] : '0;
`endif
        end
        m_to <= m_to + 1;
      end else begin
        m_to <= 0;
      end
      if (!bad) begin
        if (m_st == IDLE && start) m_st <= RUN;
        else if (m_st == RUN && halt) m_st <= DRAIN;
        else if (m_st == DRAIN && !dn && !rn) begin
          m_st <= PASS; m_pass <= 1;
        end
      end
      if (dpush) dq.push_back(ind);
      if (rpush) rq.push_back(inr);
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", state_o, m_st);
      chk("err_code", err_code, m_err);
      chk("fail_pc", fail_pc, m_fpc);
      chk("match_cnt", match_cnt, m_cnt);
      chk("pass", pass, m_pass);
      chk("fail", fail, m_fail);
      chk("dut_ready", dut_ready,
          (m_st == RUN || m_st == DRAIN) && dq.size() < DEPTH);
      chk("ref_ready", ref_ready,
          (m_st == RUN || m_st == DRAIN) && rq.size() < DEPTH);
      chk("mm_dut_rec", mm_dut_rec, m_mmd);
      chk("mm_ref_rec", mm_ref_rec, m_mmr);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; halt = 0; dut_valid = 0; ref_valid = 0;
    set_d('0); set_r('0);
  endtask

  task automatic do_rst();
    idle_in();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic go();
    start = 1; tick(); start = 0;
  endtask

  task automatic wait_state(cmp_state_t s, int max, string nm);
    for (int i = 0; i < max && state_o != s; i++) tick();
    chk(nm, state_o, s);
  endtask

  initial begin
    int bp;
    rst = 1;
    idle_in();
    tick(); tick();
    rst = 0;
    chk("reset_state", state_o, 3'd0);
    chk("reset_ready", {dut_ready, ref_ready}, 2'b00);

    // lockstep match of 20 records
    go();
    for (int i = 0; i < 20; i++) begin
      dut_valid = 1; ref_valid = 1;
      set_d(mk(32'(4 * i), 1'b1, 5'(i + 1), 32'(i * 7)));
      set_r(mk(32'(4 * i), 1'b1, 5'(i + 1), 32'(i * 7)));
      tick();
    end
    dut_valid = 0; ref_valid = 0; halt = 1; tick(); halt = 0;
    wait_state(PASS, 10, "lock_state");
    chk("lock_cnt", match_cnt, 32'd20);
    chk("lock_pass", pass, 1'b1);
    chk("lock_err", err_code, 2'd0);

    // reference lags by 5 cycles
    do_rst(); go();
    bp = 0;
    for (int c = 0; c < 13; c++) begin
      if (!dut_ready) bp++;
      dut_valid = (c < 8);
      ref_valid = (c >= 5);
      if (c < 8) set_d(mk(32'h200 + 32'(4 * c), 1'b0, 5'd0, 32'd0));
      if (c >= 5) set_r(mk(32'h200 + 32'(4 * (c - 5)), 1'b0, 5'd0, 32'd0));
      tick();
    end
    dut_valid = 0; ref_valid = 0; halt = 1; tick(); halt = 0;
    wait_state(PASS, 10, "skew_state");
    chk("skew_cnt", match_cnt, 32'd8);
    chk("skew_no_bp", bp, 0);
    chk("skew_err", err_code, 2'd0);

    // data mismatch on the fourth pair
    do_rst(); go();
    for (int i = 0; i < 4; i++) begin
      dut_valid = 1; ref_valid = 1;
      if (i < 3) begin
        set_d(mk(32'(4 * i), 1'b0, 5'd0, 32'd0));
        set_r(mk(32'(4 * i), 1'b0, 5'd0, 32'd0));
      end else begin
        set_d(mk(32'hC, 1'b1, 5'd5, 32'h11));
        set_r(mk(32'hC, 1'b1, 5'd5, 32'h12));
      end
      tick();
    end
    idle_in();
    wait_state(FAIL, 10, "mm_state");
    chk("mm_err", err_code, 2'd1);
    chk("mm_fpc", fail_pc, 32'hC);
    chk("mm_cnt", match_cnt, 32'd3);
    chk("mm_fail", fail, 1'b1);
`ifdef COMMIT_CMP_LOG_EN
    chk("mm_log_d", mm_dut_rec, mk(32'hC, 1'b1, 5'd5, 32'h11));
    chk("mm_log_r", mm_ref_rec, mk(32'hC, 1'b1, 5'd5, 32'h12));
`else
    chk("mm_log_off", {mm_dut_rec, mm_ref_rec}, '0);
`endif

    // x0 writes with different data still match
    do_rst(); go();
    for (int i = 0; i < 2; i++) begin
      dut_valid = 1; ref_valid = 1;
      set_d(mk(32'h300 + 32'(4 * i), 1'b1, 5'd0, 32'hAAAA));
      set_r(mk(32'h300 + 32'(4 * i), 1'b1, 5'd0, 32'h5555));
      tick();
    end
    idle_in(); halt = 1; tick(); halt = 0;
    wait_state(PASS, 10, "x0_state");
    chk("x0_cnt", match_cnt, 32'd2);

    // one-sided record times out 16 cycles after it arrives
    do_rst(); go();
    dut_valid = 1; set_d(mk(32'h40, 1'b0, 5'd0, 32'd0)); tick();
    idle_in();
    for (int i = 0; i < TMO - 1; i++) tick();
    chk("tmo_not_yet", state_o, 3'd1);
    tick();
    chk("tmo_state", state_o, 3'd4);
    chk("tmo_err", err_code, 2'd2);
    chk("tmo_fpc", fail_pc, 32'h40);
`ifdef COMMIT_CMP_LOG_EN
    chk("tmo_log_d", mm_dut_rec, mk(32'h40, 1'b0, 5'd0, 32'd0));
    chk("tmo_log_r", mm_ref_rec, '0);
`endif

    // fill DUT FIFO, then reset mid-test
    do_rst(); go();
    for (int i = 0; i < 9; i++) begin
      dut_valid = 1;
      set_d(mk(32'h100 + 32'(4 * i), 1'b0, 5'd0, 32'd0));
      tick();
    end
    chk("bp_ready", dut_ready, 1'b0);
    do_rst();
    chk("rst_state", state_o, 3'd0);
    chk("rst_cnt", match_cnt, 32'd0);
    chk("rst_ready", dut_ready, 1'b0);
    go();
    halt = 1; tick(); halt = 0;
    wait_state(PASS, 3, "rst_empty_pass");

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
